// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter and SPI frame sequencer: serves one byte-wide read or
// write frame at a time from NUM_REQ requesters onto a single SPI slave port.
module spi_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                      sclk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      ssel,
  output logic                      rd_wr,
  output logic                      mosi,
  input  logic                      miso
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW    = IDX_W + 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CW-1:0]    NUM_C    = CW'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] NEXT_TOP = BIT_W'(DATA_W - 2);
  localparam logic [BIT_W-1:0] ONE_BIT  = BIT_W'(1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0] ONE_GAP  = GAP_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [BIT_W-1:0]   bit_cnt_r, bit_cnt_s;
  logic [GAP_W-1:0]   gap_cnt_r, gap_cnt_s;
  logic [IDX_W-1:0]   rr_r, rr_s;
  logic [IDX_W-1:0]   win_r, win_s;
  logic               dir_r, dir_s;
  logic [DATA_W-1:0]  wdata_r, wdata_s;
  logic [DATA_W-1:0]  shift_r, shift_s;
  logic [DATA_W-1:0]  rdata_s;
  logic [NUM_REQ-1:0] gnt_s, done_s;
  logic               busy_s, ssel_s, rd_wr_s, mosi_s;
  logic [IDX_W:0]     pick_s;

  // Search starting at ptr; the lowest rotation offset wins. Returns {found, index}.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [IDX_W-1:0]   ptr);
    logic [IDX_W:0] res;
    logic [CW-1:0]  sum;
    res = {CW{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + CW'(k);
      sum = (sum >= NUM_C) ? (sum - NUM_C) : sum;
      res = r[sum[IDX_W-1:0]] ? {1'b1, sum[IDX_W-1:0]} : res;
    end
    return res;
  endfunction

  function automatic logic [DATA_W-1:0] sel_wdata(input logic [NUM_REQ*DATA_W-1:0] d,
                                                  input logic [IDX_W-1:0]          idx);
    logic [DATA_W-1:0] sel;
    sel = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      sel = (IDX_W'(i) == idx) ? d[i*DATA_W +: DATA_W] : sel;
    end
    return sel;
  endfunction

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_s   = state_r;
    bit_cnt_s = bit_cnt_r;
    gap_cnt_s = gap_cnt_r;
    rr_s      = rr_r;
    win_s     = win_r;
    dir_s     = dir_r;
    wdata_s   = wdata_r;
    shift_s   = shift_r;
    rdata_s   = rdata;
    gnt_s     = {NUM_REQ{1'b0}};
    done_s    = {NUM_REQ{1'b0}};
    ssel_s    = 1'b1;
    rd_wr_s   = rd_wr;
    mosi_s    = 1'b0;
    pick_s    = rr_pick(req, rr_r);
    case (state_r)
      IDLE: begin
        if (pick_s[IDX_W]) begin
          state_s = SETUP;
          win_s   = pick_s[IDX_W-1:0];
          dir_s   = req_wr[pick_s[IDX_W-1:0]];
          wdata_s = sel_wdata(req_wdata, pick_s[IDX_W-1:0]);
          rr_s    = (pick_s[IDX_W-1:0] == LAST_IDX) ? {IDX_W{1'b0}}
                                                    : (pick_s[IDX_W-1:0] + ONE_IDX);
          gnt_s[pick_s[IDX_W-1:0]] = 1'b1;
          ssel_s  = 1'b0;
          rd_wr_s = req_wr[pick_s[IDX_W-1:0]];
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        state_s   = XFER;
        bit_cnt_s = {BIT_W{1'b0}};
        ssel_s    = 1'b0;
        mosi_s    = dir_r & wdata_r[LAST_BIT];
      end
      XFER: begin
        shift_s = dir_r ? shift_r : {shift_r[DATA_W-2:0], miso};
        if (bit_cnt_r == LAST_BIT) begin
          // Last bit: the final miso sample lands directly in rdata.
          state_s   = GAP;
          bit_cnt_s = {BIT_W{1'b0}};
          gap_cnt_s = {GAP_W{1'b0}};
          done_s[win_r] = 1'b1;
          rdata_s   = dir_r ? rdata : {shift_r[DATA_W-2:0], miso};
        end else begin
          bit_cnt_s = bit_cnt_r + ONE_BIT;
          ssel_s    = 1'b0;
          mosi_s    = dir_r & wdata_r[NEXT_TOP - bit_cnt_r];
        end
      end
      GAP: begin
        if (gap_cnt_r == LAST_GAP) begin
          state_s   = IDLE;
          gap_cnt_s = {GAP_W{1'b0}};
        end else begin
          gap_cnt_s = gap_cnt_r + ONE_GAP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      bit_cnt_r <= {BIT_W{1'b0}};
      gap_cnt_r <= {GAP_W{1'b0}};
      rr_r      <= {IDX_W{1'b0}};
      win_r     <= {IDX_W{1'b0}};
      dir_r     <= 1'b0;
      wdata_r   <= {DATA_W{1'b0}};
      shift_r   <= {DATA_W{1'b0}};
      rdata     <= {DATA_W{1'b0}};
      gnt       <= {NUM_REQ{1'b0}};
      done      <= {NUM_REQ{1'b0}};
      busy      <= 1'b0;
      ssel      <= 1'b1;
      rd_wr     <= 1'b0;
      mosi      <= 1'b0;
    end else begin
      state_r   <= state_s;
      bit_cnt_r <= bit_cnt_s;
      gap_cnt_r <= gap_cnt_s;
      rr_r      <= rr_s;
      win_r     <= win_s;
      dir_r     <= dir_s;
      wdata_r   <= wdata_s;
      shift_r   <= shift_s;
      rdata     <= rdata_s;
      gnt       <= gnt_s;
      done      <= done_s;
      busy      <= busy_s;
      ssel      <= ssel_s;
      rd_wr     <= rd_wr_s;
      mosi      <= mosi_s;
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Self-checking bench for spi_req_arbiter: expected frames are queued when a
// request is raised and compared against the observed frame when it completes.
module tb_spi_req_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int GAP     = 1;

  logic                      sclk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_REQ-1:0]        req = 4'b0000;
  logic [NUM_REQ-1:0]        req_wr = 4'b0000;
  logic [NUM_REQ*DATA_W-1:0] req_wdata = 32'h0000_0000;
  logic                      miso = 1'b0;
  logic [NUM_REQ-1:0]        gnt, done;
  logic [DATA_W-1:0]         rdata;
  logic                      busy, ssel, rd_wr, mosi;

  spi_req_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .GAP_CYCLES(GAP)) dut (
    .sclk(sclk), .rst_n(rst_n), .req(req), .req_wr(req_wr), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .busy(busy), .ssel(ssel),
    .rd_wr(rd_wr), .mosi(mosi), .miso(miso)
  );

  always #5 sclk = ~sclk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         idx;
    logic       wr;
    logic [7:0] wbyte;
    logic [7:0] rbyte;
  } frame_t;

  frame_t     exp_q[$];
  logic [7:0] last_rd = 8'h00;

  // Observations of the most recent frame
  bit         obs_timeout;
  bit         obs_gnt_onehot;
  int         obs_gnt_idx;
  int         obs_ssel_low;
  int         obs_wait;
  logic [7:0] obs_mosi;
  logic       obs_rdwr;
  bit         obs_rdwr_var;
  bit         obs_busy_ok;
  bit         obs_early;
  logic [3:0] obs_done;
  logic [7:0] obs_rdata;
  logic       obs_ssel_gap;

  function automatic frame_t mk(input int idx, input logic wr, input logic [7:0] wb,
                                input logic [7:0] rb);
    frame_t f;
    f.idx = idx; f.wr = wr; f.wbyte = wb; f.rbyte = rb;
    return f;
  endfunction

  // Waits for a grant, plays the slave (miso = sb MSB first), records the frame.
  task automatic collect(input logic [7:0] sb, input bit drop, input bit late);
    logic prev_rw;
    obs_timeout = 1'b1; obs_gnt_idx = -1; obs_rdwr_var = 1'b0; obs_busy_ok = 1'b1;
    obs_early = 1'b0; obs_ssel_low = 0; obs_mosi = 8'h00; obs_wait = 0;
    obs_gnt_onehot = 1'b0;
    prev_rw = rd_wr;
    for (int c = 0; c < 60; c++) begin
      @(negedge sclk);
      obs_wait++;
      if (gnt !== 4'b0000) begin
        obs_timeout = 1'b0;
        break;
      end
      if (rd_wr !== prev_rw) obs_rdwr_var = 1'b1;
    end
    if (obs_timeout) return;
    obs_gnt_onehot = $onehot(gnt);
    for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) obs_gnt_idx = i;
    obs_rdwr = rd_wr;
    if (ssel === 1'b0) obs_ssel_low++;
    if (busy !== 1'b1) obs_busy_ok = 1'b0;
    miso = sb[7];
    if (drop) req[obs_gnt_idx] = 1'b0;
    if (late) begin
      req_wdata[7:0] = 8'hFF;
      req_wr[0] = ~req_wr[0];
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge sclk);
      obs_mosi[7-k] = mosi;
      miso = sb[7-k];
      if (ssel === 1'b0) obs_ssel_low++;
      if (rd_wr !== obs_rdwr) obs_rdwr_var = 1'b1;
      if (busy !== 1'b1) obs_busy_ok = 1'b0;
      if (done !== 4'b0000 || gnt !== 4'b0000) obs_early = 1'b1;
    end
    @(negedge sclk);
    miso = 1'b0;
    obs_done = done; obs_rdata = rdata; obs_ssel_gap = ssel;
    if (busy !== 1'b1) obs_busy_ok = 1'b0;
    if (rd_wr !== obs_rdwr) obs_rdwr_var = 1'b1;
  endtask

  // Pops the next expected frame, observes the DUT's frame, compares.
  task automatic score(input string tag, input bit drop, input bit late);
    frame_t     e;
    logic [3:0] exp_done;
    logic [7:0] exp_mosi, exp_rdata;
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL %s_queue: scoreboard empty", tag); return;
    end
    e = exp_q.pop_front();
    collect(e.rbyte, drop, late);
    checks++;
    if (obs_timeout) begin
      errors++; $display("FAIL %s_timeout: no gnt seen, want gnt[%0d]", tag, e.idx); return;
    end
    exp_done  = 4'b0001 << e.idx;
    exp_mosi  = e.wr ? e.wbyte : 8'h00;
    exp_rdata = e.wr ? last_rd : e.rbyte;
    last_rd   = exp_rdata;
    checks++;
    if (obs_gnt_idx != e.idx || !obs_gnt_onehot) begin
      errors++; $display("FAIL %s_gnt: got idx %0d onehot %0d, want idx %0d", tag, obs_gnt_idx, obs_gnt_onehot, e.idx);
    end
    checks++;
    if (obs_ssel_low != 9) begin
      errors++; $display("FAIL %s_ssel_low: got %0d cycles, want 9", tag, obs_ssel_low);
    end
    checks++;
    if (obs_rdwr !== e.wr || obs_rdwr_var) begin
      errors++; $display("FAIL %s_rd_wr: got %b (unstable=%0d), want %b stable", tag, obs_rdwr, obs_rdwr_var, e.wr);
    end
    checks++;
    if (obs_mosi !== exp_mosi) begin
      errors++; $display("FAIL %s_mosi: got %h, want %h", tag, obs_mosi, exp_mosi);
    end
    checks++;
    if (obs_done !== exp_done || obs_early) begin
      errors++; $display("FAIL %s_done: got %b (early=%0d), want %b", tag, obs_done, obs_early, exp_done);
    end
    checks++;
    if (obs_rdata !== exp_rdata) begin
      errors++; $display("FAIL %s_rdata: got %h, want %h", tag, obs_rdata, exp_rdata);
    end
    checks++;
    if (obs_ssel_gap !== 1'b1 || !obs_busy_ok) begin
      errors++; $display("FAIL %s_gap: ssel %b busy_ok %0d, want ssel 1 busy_ok 1", tag, obs_ssel_gap, obs_busy_ok);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'b1111;
    repeat (2) @(negedge sclk);
    checks++; if (ssel !== 1'b1) begin errors++; $display("FAIL reset_ssel: got %b want 1", ssel); end
    checks++; if (rd_wr !== 1'b0) begin errors++; $display("FAIL reset_rd_wr: got %b want 0", rd_wr); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b want 0000", done); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    req = 4'b0000;
    rst_n = 1'b1;
    repeat (3) @(negedge sclk);
    checks++;
    if (busy !== 1'b0 || ssel !== 1'b1) begin
      errors++; $display("FAIL idle_quiet: busy %b ssel %b, want busy 0 ssel 1", busy, ssel);
    end
  endtask

  task automatic test_single_write();
    req_wr[0] = 1'b1;
    req_wdata[7:0] = 8'hA5;
    exp_q.push_back(mk(0, 1'b1, 8'hA5, 8'h00));
    req[0] = 1'b1;
    score("wr0", 1'b1, 1'b0);
    checks++;
    if (obs_wait != 1) begin
      errors++; $display("FAIL wr0_latency: gnt after %0d cycles, want 1", obs_wait);
    end
  endtask

  task automatic test_single_read();
    req_wr[2] = 1'b0;
    req_wdata[23:16] = 8'hFF;
    exp_q.push_back(mk(2, 1'b0, 8'h00, 8'h3C));
    req[2] = 1'b1;
    score("rd2", 1'b1, 1'b0);
  endtask

  task automatic test_direction();
    logic [7:0] wbytes [3];
    wbytes[0] = 8'hC3; wbytes[1] = 8'h77; wbytes[2] = 8'h0F;
    for (int f = 0; f < 3; f++) begin
      req_wr[3] = (f != 1);
      req_wdata[31:24] = wbytes[f];
      exp_q.push_back(mk(3, (f != 1), wbytes[f], 8'h5A));
      req[3] = 1'b1;
      score($sformatf("dir%0d", f), 1'b1, 1'b0);
      if (f > 0) begin
        checks++;
        if (obs_wait != GAP + 1) begin
          errors++; $display("FAIL dir%0d_period: gnt after %0d cycles, want %0d", f, obs_wait, GAP + 1);
        end
      end
    end
  endtask

  task automatic test_contention();
    req_wr = 4'b0101;
    req_wdata = {8'hFF, 8'h24, 8'hFF, 8'h81};
    exp_q.push_back(mk(0, 1'b1, 8'h81, 8'h00));
    exp_q.push_back(mk(1, 1'b0, 8'h00, 8'h96));
    exp_q.push_back(mk(2, 1'b1, 8'h24, 8'h00));
    exp_q.push_back(mk(3, 1'b0, 8'h00, 8'h4E));
    exp_q.push_back(mk(0, 1'b1, 8'h81, 8'h00));
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      score($sformatf("cont%0d", f), 1'b0, 1'b0);
      if (f > 0) begin
        checks++;
        if (obs_wait != GAP + 1) begin
          errors++; $display("FAIL cont%0d_period: gnt after %0d cycles, want %0d", f, obs_wait, GAP + 1);
        end
      end
    end
    req = 4'b1110;
    exp_q.push_back(mk(1, 1'b0, 8'h00, 8'hD2));
    score("late0_g1", 1'b1, 1'b0);
    req[0] = 1'b1;
    exp_q.push_back(mk(2, 1'b1, 8'h24, 8'h00));
    exp_q.push_back(mk(3, 1'b0, 8'h00, 8'h17));
    exp_q.push_back(mk(0, 1'b1, 8'h81, 8'h00));
    for (int f = 0; f < 3; f++) score($sformatf("late0_r%0d", f), 1'b1, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL cont_leftover: %0d frames not served, want 0", exp_q.size());
    end
  endtask

  task automatic test_late_change();
    req_wr[0] = 1'b1;
    req_wdata[7:0] = 8'h96;
    exp_q.push_back(mk(0, 1'b1, 8'h96, 8'h00));
    req[0] = 1'b1;
    score("late_chg", 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] done_seen;
    req_wr = 4'b1111;
    req_wdata = {8'h6B, 8'hE7, 8'h5D, 8'h00};
    req = 4'b0100;
    for (int c = 0; c < 40; c++) begin
      @(negedge sclk);
      if (gnt !== 4'b0000) break;
    end
    checks++;
    if (gnt !== 4'b0100) begin
      errors++; $display("FAIL rstmid_gnt: got %b want 0100", gnt);
    end
    req = 4'b1010;
    repeat (5) @(negedge sclk);
    checks++;
    if (ssel !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_inframe: ssel %b busy %b, want 0 1", ssel, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ssel !== 1'b1 || mosi !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_immediate: ssel %b mosi %b busy %b, want 1 0 0", ssel, mosi, busy);
    end
    done_seen = 4'b0000;
    repeat (3) begin
      @(negedge sclk);
      done_seen = done_seen | done;
    end
    rst_n = 1'b1;
    last_rd = 8'h00;
    checks++;
    if (done_seen !== 4'b0000 || rdata !== 8'h00) begin
      errors++; $display("FAIL rstmid_nodone: done %b rdata %h, want 0000 00", done_seen, rdata);
    end
    exp_q.push_back(mk(1, 1'b1, 8'h5D, 8'h00));
    score("rstmid_regrant", 1'b1, 1'b0);
    req[3] = 1'b0;
    repeat (3) @(negedge sclk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle: busy %b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_direction();
    test_contention();
    test_late_change();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
